// File: rtl/shared_timer_sched.sv
// Round-robin shared down-counting delay timer: one requester at a time owns the counter.
// Optional tick prescaler enabled by defining SHARED_TIMER_SCHED_PRESCALE_EN.
module shared_timer_sched #(
  parameter int NREQ  = 4,
  parameter int CW    = 16,
  parameter int PRESC = 50
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] delay_i,
  input  logic              abort,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [CW-1:0]     cur_cnt
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (NREQ < 2 || PRESC < 2) begin : g_bad_cfg
    $error("shared_timer_sched: NREQ and PRESC must both be >= 2");
  end

  logic [1:0]               state;
  logic [IW-1:0]            g, ptr, pick, idx;
  logic                     found;
  logic [CW-1:0]            cnt;
  logic                     tick;
  logic [NREQ-1:0]          pick_oh;
  logic [NREQ-1:0][CW-1:0]  dly;
  logic [CW-1:0]            d_sel;

  assign dly   = delay_i;
  assign d_sel = dly[g];

  // Scan starts just after the last owner, so whoever finished goes to the back of the line.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_oh = NREQ'(1) << pick;

`ifdef SHARED_TIMER_SCHED_PRESCALE_EN
  localparam int PW = $clog2(PRESC);
  logic [PW-1:0] pcnt;

  assign tick = (pcnt == PW'(PRESC - 1));

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)                 pcnt <= '0;
    else if (state == S_LOAD)  pcnt <= '0;
    else if (state == S_RUN)   pcnt <= tick ? '0 : pcnt + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= S_IDLE;
      grant <= '0;
      cnt   <= '0;
      g     <= '0;
      ptr   <= IW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state <= S_LOAD;
            g     <= pick;
            grant <= pick_oh;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
            grant <= '0;
            cnt   <= '0;
            ptr   <= g;
          end else begin
            cnt   <= d_sel;
            state <= (d_sel == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          // Abort takes precedence even on the expiring tick: no done pulse.
          if (abort) begin
            state <= S_IDLE;
            grant <= '0;
            cnt   <= '0;
            ptr   <= g;
          end else if (tick) begin
            if (cnt == CW'(1))  state <= S_DONE;
            else if (cnt != '0) cnt   <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
          cnt   <= '0;
          ptr   <= g;
        end
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE) ? grant : '0;
  assign cur_cnt = cnt;

endmodule

// File: tb/tb_shared_timer_sched.sv
// Bench for shared_timer_sched: timeline model of owner/grant-age checked every cycle,
// plus directed scenarios with literal expectations (prescaler build: SHARED_TIMER_SCHED_PRESCALE_EN).
module tb_shared_timer_sched;

`ifdef SHARED_TIMER_SCHED_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic        clk = 1'b0;
  logic        aclr = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] delay_i = '0;
  logic        abort = 1'b0;
  logic [3:0]  grant, done;
  logic        busy;
  logic [15:0] cur_cnt;

  shared_timer_sched #(.NREQ(4), .CW(16), .PRESC(4)) dut (
    .clk(clk), .aclr(aclr), .req(req), .delay_i(delay_i), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .cur_cnt(cur_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: an owner holds the timer for ages 0..1+D*P counted from its grant cycle.
  int m_own = -1, m_t0 = 0, m_d = 0, m_ptr = 3, age = 0;
  logic [3:0]  eg, ed;
  logic        eb;
  logic [15:0] ec;
  logic        m_found;

  always @(negedge clk) begin
    if (!aclr) begin
      tests++;
      if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || cur_cnt !== 16'd0) begin
        fails++;
        $display("FAIL reset_hold: grant=%b done=%b busy=%b cnt=%0d expected all 0", grant, done, busy, cur_cnt);
      end
      m_own = -1;
      m_ptr = 3;
    end else begin
      eg = '0; ed = '0; eb = 1'b0; ec = '0; age = 0;
      if (m_own >= 0) begin
        age = cyc - m_t0;
        eg[m_own] = 1'b1;
        eb = 1'b1;
        if (age >= 1) begin
          if (age == 1 + m_d * P) begin
            ed[m_own] = 1'b1;
            ec = (m_d == 0) ? 16'd0 : 16'd1;
          end else begin
            ec = 16'(m_d - (age - 1) / P);
          end
        end
      end
      tests++;
      if (grant !== eg || done !== ed || busy !== eb || cur_cnt !== ec) begin
        fails++;
        $display("FAIL model cyc %0d: grant=%b/%b done=%b/%b busy=%b/%b cnt=%0d/%0d (got/expected)",
                 cyc, grant, eg, done, ed, busy, eb, cur_cnt, ec);
      end
      if (m_own >= 0) begin
        if (age == 0) m_d = int'(delay_i[m_own*16 +: 16]);
        if (age == 1 + m_d * P || (abort && age < 1 + m_d * P)) begin
          m_ptr = m_own;
          m_own = -1;
        end
      end else if (|req) begin
        m_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          if (!m_found && req[(m_ptr + i) % 4]) begin
            m_found = 1'b1;
            m_own = (m_ptr + i) % 4;
          end
        end
        m_t0 = cyc + 1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin step(1); n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic wait_cnt(input logic [15:0] v);
    int n = 0;
    while (cur_cnt != v && n < 500) begin step(1); n++; end
    if (cur_cnt != v) begin
      tests++; fails++;
      $display("FAIL wait_cnt: cur_cnt %0d never reached %0d", cur_cnt, v);
    end
  endtask

  task automatic do_reset();
    aclr = 1'b0;
    step(1);
    aclr = 1'b1;
    step(1);
  endtask

  initial begin
    #2 aclr = 1'b0;
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_cnt", 32'(cur_cnt), 32'h0);
    step(2);
    aclr = 1'b1;
    step(1);

    // 1: single requester, delay 5; delay_i change mid-run must not matter
    delay_i[15:0] = 16'd5;
    req = 4'b0001;
    step(1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    step(1);
    delay_i[15:0] = 16'd9;
`ifndef SHARED_TIMER_SCHED_PRESCALE_EN
    for (int k = 0; k < 5; k++) begin
      chk("t1_cnt", 32'(cur_cnt), 32'(5 - k));
      step(1);
    end
    chk("t1_done", 32'(done), 32'h1);
    step(1);
    chk("t1_grant_clr", 32'(grant), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);
`endif
    wait_idle();

    // 2: all four request, delay 2 each -> strict rotation 0,1,2,3
    do_reset();
    delay_i = {4{16'd2}};
    req = 4'b1111;
    step(1);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << k;
      chk("t2_grant", 32'(grant), 32'(oh));
      if (k == 3) req = 4'b0000;
      step(1 + 2 * P);
      chk("t2_done", 32'(done), 32'(oh));
      step(2);
    end
    wait_idle();

    // 3: zero delay
    delay_i[47:32] = 16'd0;
    req = 4'b0100;
    step(1);
    chk("t3_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    step(1);
    chk("t3_done", 32'(done), 32'h4);
    step(1);
    chk("t3_idle", 32'(busy), 32'h0);

    // 4: abort at cur_cnt==3, pending ch2 granted one cycle later
    delay_i[31:16] = 16'd10;
    delay_i[47:32] = 16'd1;
    req = 4'b0010;
    step(1);
    chk("t4_grant", 32'(grant), 32'h2);
    req = 4'b0100;
    wait_cnt(16'd3);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_abort_busy", 32'(busy), 32'h0);
    chk("t4_abort_done", 32'(done), 32'h0);
    step(1);
    chk("t4_next_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    wait_idle();

    // 4b: abort on the expiring tick suppresses done
    delay_i[15:0] = 16'd2;
    req = 4'b0001;
    step(1);
    req = 4'b0000;
    wait_cnt(16'd1);
    step(P - 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4b_no_done", 32'(done), 32'h0);
    chk("t4b_idle", 32'(busy), 32'h0);

    // 5: reset mid-run, then ch0 wins first
    delay_i[31:16] = 16'd10;
    req = 4'b0010;
    step(1);
    wait_cnt(16'd7);
    req = 4'b0011;
    aclr = 1'b0;
    #1;
    chk("t5_grant", 32'(grant), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_cnt", 32'(cur_cnt), 32'h0);
    step(1);
    aclr = 1'b1;
    step(1);
    chk("t5_first", 32'(grant), 32'h1);
    req = 4'b0000;
    wait_idle();

`ifdef SHARED_TIMER_SCHED_PRESCALE_EN
    // 6: prescaled, ch3 delay 3 -> done 14 cycles after request
    delay_i[63:48] = 16'd3;
    req = 4'b1000;
    step(1);
    chk("t6_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    step(4);
    chk("t6_cnt3", 32'(cur_cnt), 32'd3);
    step(1);
    chk("t6_cnt2", 32'(cur_cnt), 32'd2);
    step(7);
    chk("t6_not_yet", 32'(done), 32'h0);
    step(1);
    chk("t6_done", 32'(done), 32'h8);
    wait_idle();
`endif

    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
